// File: rtl/segment_to_binary_pkg.sv
// Shared seven-segment definitions for the display encoder and the
// segment_to_binary readback path, so both directions use one pattern table.
package seg_pkg;

   localparam int RESULT_W   = 16;
   localparam int BCD_DIGITS = 4;

   // Active-low segment patterns, bit order {a,b,c,d,e,f,g}
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

   // Digit-to-pattern direction used by the display encoder; anything
   // outside 0-9 shows blank.
   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      case (digit)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/segment_to_binary_if.sv
// Start/busy/valid handshake plus the four captured display patterns.
interface segment_to_binary_if;
   import seg_pkg::*;

   logic                start;
   logic [6:0]          seg0;
   logic [6:0]          seg1;
   logic [6:0]          seg2;
   logic [6:0]          seg3;
   logic                busy;
   logic                valid;
   logic [RESULT_W-1:0] binary;
   logic                err;

   // Requester side: issues patterns and start, observes the result
   modport master (
      output start, seg0, seg1, seg2, seg3,
      input  busy, valid, binary, err
   );

   // Converter side
   modport slave (
      input  start, seg0, seg1, seg2, seg3,
      output busy, valid, binary, err
   );

endinterface

// File: rtl/segment_to_binary_seg7_decode.sv
// Combinational seven-segment pattern to decimal digit decoder.
// Blank decodes as a legal 0 so leading digits may be switched off.
module seg7_decode
   import seg_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_digit,
   output logic       o_legal
);

   // Table lookup against the shared pattern constants
   always_comb begin
      o_digit = 4'd0;
      o_legal = 1'b1;
      case (i_seg)
         SEG_0:     o_digit = 4'd0;
         SEG_1:     o_digit = 4'd1;
         SEG_2:     o_digit = 4'd2;
         SEG_3:     o_digit = 4'd3;
         SEG_4:     o_digit = 4'd4;
         SEG_5:     o_digit = 4'd5;
         SEG_6:     o_digit = 4'd6;
         SEG_7:     o_digit = 4'd7;
         SEG_8:     o_digit = 4'd8;
         SEG_9:     o_digit = 4'd9;
         SEG_BLANK: o_digit = 4'd0;
         default:   o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/segment_to_binary.sv
// Four-digit seven-segment readback to 16-bit binary converter.
// Uses reverse double-dabble: shift {bcd,acc} right, then correct every
// BCD nibble that reached 8 or more by subtracting 3.
module segment_to_binary
   import seg_pkg::*;
#(
   parameter int CONV_CYCLES = 16
)
(
   input  logic               clk,
   input  logic               rst_n,
   segment_to_binary_if.slave bus
);

   localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(CONV_CYCLES - 1);

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [RESULT_W-1:0]     r_bcd;
   logic [RESULT_W-1:0]     r_acc;
   logic                    r_busy;
   logic                    r_valid;
   logic [RESULT_W-1:0]     r_binary;
   logic                    r_err;

   logic [3:0]              w_d0, w_d1, w_d2, w_d3;
   logic [BCD_DIGITS-1:0]   w_legal;
   logic                    w_all_legal;
   logic [2*RESULT_W-1:0]   w_shift;
   logic [RESULT_W-1:0]     w_bcd_next;
   logic [RESULT_W-1:0]     w_acc_next;

   // Subtract 3 from each BCD nibble that is 8 or more after the shift
   function automatic logic [RESULT_W-1:0] bcd_adjust(input logic [RESULT_W-1:0] b);
      logic [RESULT_W-1:0] r;
      r = b;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (r[4*i +: 4] >= 4'd8)
            r[4*i +: 4] = r[4*i +: 4] - 4'd3;
      end
      return r;
   endfunction

   seg7_decode u_dec0 (.i_seg(bus.seg0), .o_digit(w_d0), .o_legal(w_legal[0]));
   seg7_decode u_dec1 (.i_seg(bus.seg1), .o_digit(w_d1), .o_legal(w_legal[1]));
   seg7_decode u_dec2 (.i_seg(bus.seg2), .o_digit(w_d2), .o_legal(w_legal[2]));
   seg7_decode u_dec3 (.i_seg(bus.seg3), .o_digit(w_d3), .o_legal(w_legal[3]));

   assign w_all_legal = &w_legal;
   assign w_shift     = {r_bcd, r_acc} >> 1;
   assign w_bcd_next  = bcd_adjust(w_shift[2*RESULT_W-1:RESULT_W]);
   assign w_acc_next  = w_shift[RESULT_W-1:0];

   // Control FSM, shift datapath and result registers. The result is
   // registered on the edge that enters DONE so valid/binary/err are
   // visible during the DONE cycle itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_bcd    <= '0;
         r_acc    <= '0;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
         r_binary <= '0;
         r_err    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_busy <= 1'b1;
                  r_cnt  <= '0;
                  r_acc  <= '0;
                  if (w_all_legal) begin
                     r_bcd   <= {w_d3, w_d2, w_d1, w_d0};
                     r_state <= CONVERT;
                  end else begin
                     r_bcd    <= '0;
                     r_valid  <= 1'b1;
                     r_binary <= '0;
                     r_err    <= 1'b1;
                     r_state  <= DONE;
                  end
               end
            end
            CONVERT: begin
               r_bcd <= w_bcd_next;
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_ITER) begin
                  r_valid  <= 1'b1;
                  r_binary <= w_acc_next;
                  r_err    <= 1'b0;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.valid  = r_valid;
   assign bus.binary = r_binary;
   assign bus.err    = r_err;

endmodule

// File: tb/tb_segment_to_binary.sv
// Scoreboard bench for segment_to_binary: stimulus pushes expected results,
// a negedge monitor pops and compares on every valid pulse.
module tb_segment_to_binary;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   segment_to_binary_if bus ();

   segment_to_binary #(.CONV_CYCLES(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] bin;
      logic        err;
      int          cyc;
   } exp_t;

   localparam logic [6:0] P0 = 7'b0000001;
   localparam logic [6:0] P1 = 7'b1001111;
   localparam logic [6:0] P2 = 7'b0010010;
   localparam logic [6:0] P3 = 7'b0000110;
   localparam logic [6:0] P4 = 7'b1001100;
   localparam logic [6:0] P5 = 7'b0100100;
   localparam logic [6:0] P6 = 7'b0100000;
   localparam logic [6:0] P7 = 7'b0001111;
   localparam logic [6:0] P8 = 7'b0000000;
   localparam logic [6:0] P9 = 7'b0000100;
   localparam logic [6:0] PB = 7'b1111111;
   localparam logic [6:0] PA = 7'b0001000;

   exp_t sb[$];
   exp_t mon_e;
   int   checks      = 0;
   int   failures    = 0;
   int   cyc         = 0;
   int   valid_count = 0;
   logic prev_valid  = 1'b0;
   int   vc0;
   int   busy_hi;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every valid pulse must match the oldest expected result
   always @(negedge clk) begin
      if (rst_n && bus.valid) begin
         valid_count <= valid_count + 1;
         chk("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got valid=1 binary=%0h expected no valid", bus.binary);
         end else begin
            mon_e = sb.pop_front();
            chk("binary", {16'd0, bus.binary}, {16'd0, mon_e.bin});
            chk("err", {31'd0, bus.err}, {31'd0, mon_e.err});
            chk("valid_cycle", cyc, mon_e.cyc);
         end
      end
      prev_valid <= bus.valid;
   end

   // Drive one start pulse at a negedge; accepted at the following posedge
   task automatic issue(input logic [6:0] s3, input logic [6:0] s2,
                        input logic [6:0] s1, input logic [6:0] s0,
                        input logic ok, input logic [15:0] exp_bin);
      exp_t e;
      bus.seg3  = s3;
      bus.seg2  = s2;
      bus.seg1  = s1;
      bus.seg0  = s0;
      bus.start = 1'b1;
      e.bin = ok ? exp_bin : 16'h0000;
      e.err = !ok;
      e.cyc = cyc + 1 + (ok ? 16 : 0);
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      bus.seg3  = PA;
      bus.seg2  = PA;
      bus.seg1  = PA;
      bus.seg0  = PA;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (!bus.busy) break;
         @(negedge clk);
      end
      chk("idle_reached", {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      bus.seg0  = PB;
      bus.seg1  = PB;
      bus.seg2  = PB;
      bus.seg3  = PB;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_valid", {31'd0, bus.valid}, 32'd0);
      chk("rst_binary", {16'd0, bus.binary}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // "1234" with busy profile across the conversion
      issue(P1, P2, P3, P4, 1'b1, 16'h04D2);
      chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
      busy_hi = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (bus.busy) busy_hi++;
      end
      chk("busy_through_done", busy_hi, 16);
      @(negedge clk);
      chk("busy_drop", {31'd0, bus.busy}, 32'd0);

      issue(P9, P9, P9, P9, 1'b1, 16'h270F);  wait_idle();
      issue(P0, P0, P0, P0, 1'b1, 16'h0000);  wait_idle();
      issue(PB, PB, P5, P7, 1'b1, 16'h0039);  wait_idle();
      issue(P8, P0, P8, P6, 1'b1, 16'h1F96);  wait_idle();
      issue(P2, P4, P6, P8, 1'b1, 16'h09A4);  wait_idle();
      issue(P1, P3, P5, P7, 1'b1, 16'h054D);  wait_idle();

      // Illegal patterns: hex A glyph, a lone g segment, a legal one after
      issue(P1, PA, P3, P4, 1'b0, 16'h0000);  wait_idle();
      issue(P0, P0, P0, 7'b1111110, 1'b0, 16'h0000);  wait_idle();
      issue(P0, P0, P4, P2, 1'b1, 16'h002A);  wait_idle();

      // start during busy is ignored; back-to-back start right after DONE
      vc0 = valid_count;
      issue(P1, P2, P3, P4, 1'b1, 16'h04D2);
      repeat (4) @(negedge clk);
      bus.seg3  = P9;
      bus.seg2  = P9;
      bus.seg1  = P9;
      bus.seg0  = P9;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();
      chk("one_valid_overlap", valid_count - vc0, 1);
      issue(P9, P9, P9, P9, 1'b1, 16'h270F);  wait_idle();

      // Reset in the middle of a conversion
      issue(P1, P2, P3, P4, 1'b1, 16'h04D2);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_valid", {31'd0, bus.valid}, 32'd0);
      chk("midrst_binary", {16'd0, bus.binary}, 32'd0);
      chk("midrst_err", {31'd0, bus.err}, 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      vc0 = valid_count;
      repeat (25) @(negedge clk);
      chk("no_valid_after_reset", valid_count - vc0, 0);
      issue(PB, PB, P5, P7, 1'b1, 16'h0039);  wait_idle();

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
